// File: rtl/serial_adder_seq.sv
// -----------------------------------------------------------------------------
// serial_adder_seq
//
// Digit-serial adder/subtractor. WIDTH-bit operands are processed DIGIT bits
// per clock through a small ripple full-adder chain; the carry between digits
// is held in a register. One operation takes N = WIDTH/DIGIT BUSY cycles plus
// one DONE cycle, trading latency for a very small adder.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits per cycle; must divide WIDTH exactly
//
// Ports
//   clk    in   1      clock, rising edge
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      request, accepted only while ready=1
//   sub    in   1      0: a+b+cin, 1: a-b (cin ignored)
//   a      in   WIDTH  operand A, sampled on accept
//   b      in   WIDTH  operand B, sampled on accept
//   cin    in   1      carry in for add mode, sampled on accept
//   ready  out  1      high in IDLE only
//   done   out  1      one-cycle pulse when sum/cout are updated
//   sum    out  WIDTH  registered result, held until the next completion
//   cout   out  1      carry out of the MSB (subtract: 1 = no borrow)
//   ovf    out  1      signed overflow, present only with SERIAL_ADDER_OVF_EN
//
// Configuration
//   SERIAL_ADDER_OVF_EN  when defined, adds the ovf output and its register.
// -----------------------------------------------------------------------------
module serial_adder_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;        // operand A shift register
    logic [WIDTH-1:0]   b_q, b_d;        // operand B (already inverted for sub)
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   part_q, part_d;  // partial result, filled from the top
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
    logic               dcarry_msb;      // carry into the top bit of this digit
`endif

    logic [DIGIT-1:0]   dsum;
    logic               dcarry;

    // DIGIT-bit ripple chain over the low bits of the operand shift registers.
    always_comb begin
        logic c;
        // NOTE: blocking assignments here model the ripple through the chain;
        // registered state below uses non-blocking assignments only.
        c    = carry_q;
        dsum = '0;
`ifdef SERIAL_ADDER_OVF_EN
        dcarry_msb = carry_q;
`endif
        for (int i = 0; i < DIGIT; i++) begin
`ifdef SERIAL_ADDER_OVF_EN
            if (i == DIGIT - 1) begin
                dcarry_msb = c;
            end
`endif
            dsum[i] = a_q[i] ^ b_q[i] ^ c;
            c       = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        dcarry = c;
    end

    // Next-state and datapath updates.
    always_comb begin
        // NOTE: every variable gets a hold-value default first so no path
        // through the case statement can infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B and force the carry.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    part_d  = '0;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dcarry;
                // New digit enters at the top; after N shifts the first digit
                // has reached bit 0.
                part_d  = (part_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    sum_d   = part_d;
                    cout_d  = dcarry;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = dcarry_msb ^ dcarry;
`endif
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the operand and partial registers are cleared too, so the
            // datapath restarts from a known all-zero state after reset.
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_seq.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_seq
//
// Directed bench for serial_adder_seq. Two instances share clock and reset:
// dut  (WIDTH=16, DIGIT=1, N=16) and dut4 (WIDTH=16, DIGIT=4, N=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_serial_adder_seq;

    logic        clk;
    logic        rst_n;

    logic        start, sub, cin;
    logic [15:0] a, b;
    logic        ready, done, cout;
    logic [15:0] sum;

    logic        start4, sub4, cin4;
    logic [15:0] a4, b4;
    logic        ready4, done4, cout4;
    logic [15:0] sum4;

`ifdef SERIAL_ADDER_OVF_EN
    logic        ovf, ovf4;
`endif

    int checks = 0;
    int errors = 0;

    serial_adder_seq #(.WIDTH(16), .DIGIT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_adder_seq #(.WIDTH(16), .DIGIT(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .sub   (sub4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .ready (ready4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the selected instance to be ready, then issues one
    // operation and counts edges from the accepting edge until done is seen.
    // edges = -1 if done never arrives.
    task automatic do_op(input bit use4, input logic [15:0] oa, input logic [15:0] ob,
                         input logic ocin, input logic osub, output int edges);
        int  w;
        bit  seen;
        w = 0;
        while (((use4 ? ready4 : ready) !== 1'b1) && w < 50) begin
            tick();
            w++;
        end
        if (use4) begin
            a4 = oa; b4 = ob; cin4 = ocin; sub4 = osub; start4 = 1'b1;
        end else begin
            a = oa; b = ob; cin = ocin; sub = osub; start = 1'b1;
        end
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 100) begin
            tick();
            edges++;
            start  = 1'b0;
            start4 = 1'b0;
            if ((use4 ? done4 : done) === 1'b1) seen = 1'b1;
        end
        if (!seen) edges = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (ready !== 1'b1)   begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
        checks++; if (cout !== 1'b0)    begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
        checks++; if (ready4 !== 1'b1 || done4 !== 1'b0 || sum4 !== 16'h0000 || cout4 !== 1'b0) begin
            errors++; $display("FAIL reset_dut4: got ready=%b done=%b sum=%h cout=%b expected 1 0 0000 0",
                               ready4, done4, sum4, cout4);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++; if (ovf !== 1'b0 || ovf4 !== 1'b0) begin
            errors++; $display("FAIL reset_ovf: got %b/%b expected 0/0", ovf, ovf4);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_basic_add();
        int e;
        do_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0, e);
        checks++; if (e != 17)          begin errors++; $display("FAIL basic_latency: got %0d expected 17", e); end
        checks++; if (sum !== 16'h0100) begin errors++; $display("FAIL basic_sum: got %h expected 0100", sum); end
        checks++; if (cout !== 1'b0)    begin errors++; $display("FAIL basic_cout: got %b expected 0", cout); end
        checks++; if (ready !== 1'b0)   begin errors++; $display("FAIL done_ready: got %b expected 0", ready); end
        tick();
        checks++; if (done !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL done_pulse: got done=%b ready=%b expected 0 1", done, ready);
        end
    endtask

    task automatic test_carry_sub();
        int e;
        do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, e);
        checks++; if (sum !== 16'h0000 || cout !== 1'b1) begin
            errors++; $display("FAIL wrap_add: got %h/%b expected 0000/1", sum, cout);
        end
        do_op(1'b0, 16'h0005, 16'h0007, 1'b1, 1'b1, e);   // cin ignored in sub
        checks++; if (sum !== 16'hFFFE || cout !== 1'b0) begin
            errors++; $display("FAIL sub_borrow: got %h/%b expected FFFE/0", sum, cout);
        end
        do_op(1'b0, 16'h0007, 16'h0005, 1'b0, 1'b1, e);
        checks++; if (sum !== 16'h0002 || cout !== 1'b1) begin
            errors++; $display("FAIL sub_noborrow: got %h/%b expected 0002/1", sum, cout);
        end
        do_op(1'b0, 16'h1234, 16'h4321, 1'b1, 1'b0, e);
        checks++; if (sum !== 16'h5556 || cout !== 1'b0) begin
            errors++; $display("FAIL add_cin: got %h/%b expected 5556/0", sum, cout);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
        do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, e);
        checks++; if (sum !== 16'h8000 || ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_d1: got %h/%b expected 8000/1", sum, ovf);
        end
        do_op(1'b0, 16'h1234, 16'h4321, 1'b1, 1'b0, e);   // restore 5556 for next test
`endif
    endtask

    task automatic test_ignore_start();
        int  w;
        while (ready !== 1'b1 && w < 50) begin tick(); w++; end
        a = 16'h0003; b = 16'h0004; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (ready !== 1'b0)   begin errors++; $display("FAIL busy_ready: got %b expected 0", ready); end
        checks++; if (sum !== 16'h5556) begin errors++; $display("FAIL busy_sum_hold: got %h expected 5556", sum); end
        w = 0;
        while (done !== 1'b1 && w < 40) begin tick(); w++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ignore_timeout: got done=%b expected 1", done); end
        checks++; if (sum !== 16'h0007 || cout !== 1'b0) begin
            errors++; $display("FAIL ignore_result: got %h/%b expected 0007/0", sum, cout);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int w, e;
        bit pulse;
        while (ready !== 1'b1 && w < 50) begin tick(); w++; end
        a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();                 // accept edge, count = 0
        start = 1'b0;
        repeat (5) tick();      // count = 5
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL midreset_state: got ready=%b done=%b expected 1 0", ready, done);
        end
        checks++; if (sum !== 16'h0000 || cout !== 1'b0) begin
            errors++; $display("FAIL midreset_regs: got %h/%b expected 0000/0", sum, cout);
        end
        pulse = 1'b0;
        repeat (20) begin tick(); if (done === 1'b1) pulse = 1'b1; end
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL midreset_nodone: got pulse=%b expected 0", pulse); end
        do_op(1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0, e);
        checks++; if (e != 17 || sum !== 16'h3333) begin
            errors++; $display("FAIL after_reset_op: got edges=%0d sum=%h expected 17 3333", e, sum);
        end
    endtask

    task automatic test_back_to_back();
        int w, e;
        while (ready !== 1'b1 && w < 50) begin tick(); w++; end
        a = 16'h8000; b = 16'h8000; cin = 1'b0; sub = 1'b0; start = 1'b1;
        w = 0;
        do begin tick(); w++; end while (done !== 1'b1 && w < 40);
        checks++; if (sum !== 16'h0000 || cout !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got %h/%b expected 0000/1", sum, cout);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL b2b_ovf: got %b expected 1", ovf); end
`endif
        e = 0;
        do begin tick(); e++; end while (done !== 1'b1 && e < 40);
        start = 1'b0;
        checks++; if (e != 18) begin errors++; $display("FAIL b2b_period: got %0d expected 18", e); end
        tick();
    endtask

    task automatic test_digit4();
        int e;
        do_op(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, e);
        checks++; if (e != 5)            begin errors++; $display("FAIL d4_latency: got %0d expected 5", e); end
        checks++; if (sum4 !== 16'h5556 || cout4 !== 1'b0) begin
            errors++; $display("FAIL d4_sum: got %h/%b expected 5556/0", sum4, cout4);
        end
        do_op(1'b1, 16'h0010, 16'h0001, 1'b0, 1'b1, e);
        checks++; if (sum4 !== 16'h000F || cout4 !== 1'b1) begin
            errors++; $display("FAIL d4_sub: got %h/%b expected 000F/1", sum4, cout4);
        end
        do_op(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, e);
        checks++; if (sum4 !== 16'h8000 || cout4 !== 1'b0) begin
            errors++; $display("FAIL d4_max: got %h/%b expected 8000/0", sum4, cout4);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++; if (ovf4 !== 1'b1) begin errors++; $display("FAIL d4_ovf: got %b expected 1", ovf4); end
`endif
    endtask

    initial begin
        start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_basic_add();
        test_carry_sub();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_digit4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
